ide_target: RTL and testbench

IDE_TARGET -- requirements
Module: ide_target

---
 rtl/ide_if.sv | 21 ++
 rtl/ide_target.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_ide_target.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ide_if.sv
// IDE host bus seen by the target: strobes, chip selects, register address and
// the two data directions. The host drives the master side, the target the slave.
interface ide_if;
    logic        ide_dior;
    logic        ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;
    logic [15:0] ide_data_in;
    logic [15:0] ide_data_out;
    logic        ide_data_oe;

    modport master (
        output ide_dior, ide_diow, ide_cs, ide_da, ide_data_in,
        input  ide_data_out, ide_data_oe
    );

    modport slave (
        input  ide_dior, ide_diow, ide_cs, ide_da, ide_data_in,
        output ide_data_out, ide_data_oe
    );
endinterface

// File: rtl/ide_target.sv
// IDE/ATA-style PIO target with NSECT sectors of 256x16 internal storage.
// Supports READ SECTORS (0x20) and WRITE SECTORS (0x30) with LBA range checks.
// Optional feature: define IDE_TARGET_IRQ_EN to add the ide_intrq output.
module ide_target #(
    parameter int NSECT       = 4,
    parameter int BUSY_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    ide_if.slave ide
`ifdef IDE_TARGET_IRQ_EN
    ,
    output logic ide_intrq
`endif
);

    localparam int AW        = (NSECT > 1) ? $clog2(NSECT) : 1;
    localparam int MEM_WORDS = (1 << AW) * 256;

    localparam logic [7:0] CMD_READ  = 8'h20;
    localparam logic [7:0] CMD_WRITE = 8'h30;
    localparam logic [7:0] ERR_IDNF  = 8'h10;
    localparam logic [7:0] ERR_ABRT  = 8'h04;

    typedef enum logic [2:0] {IDLE, RBUSY, RDRQ, WDRQ, WBUSY} state_t;

    state_t      state;
    state_t      state_next;

    logic        dior_q;
    logic        diow_q;
    logic        sel;
    logic        rd_act;
    logic        wr_act;

    logic [7:0]  error_reg;
    logic [7:0]  features;
    logic [7:0]  seccnt;
    logic [7:0]  lba0;
    logic [7:0]  lba1;
    logic [7:0]  lba2;
    logic [7:0]  drive;
    logic        err_flag;

    logic [7:0]  ptr;
    logic [8:0]  cnt;
    logic [23:0] cur_lba;
    logic [15:0] busy_cnt;

    logic [23:0]   lba_full;
    logic          lba_in_range;
    logic          next_in_range;
    logic          bsy;
    logic          drq;
    logic [7:0]    status;
    logic [AW-1:0] sect_idx;

    logic        cmd_wr;
    logic        data_rd_evt;
    logic        data_wr_evt;

    logic        load_cmd;
    logic        busy_load;
    logic        next_sector;
    logic        set_err;
    logic [7:0]  err_code;

    logic [15:0] mem [0:MEM_WORDS-1];

    // A strobe acts on the clock after its release; a release while the other
    // strobe was also low is treated as a bus conflict and ignored.
    assign sel          = (ide.ide_cs == 2'b10);
    assign rd_act       = ide.ide_dior && !dior_q && diow_q;
    assign wr_act       = ide.ide_diow && !diow_q && dior_q;

    assign lba_full      = {lba2, lba1, lba0};
    assign lba_in_range  = (lba_full < 24'(NSECT));
    assign next_in_range = ((cur_lba + 24'd1) < 24'(NSECT));
    assign sect_idx      = cur_lba[AW-1:0];

    assign bsy    = (state == RBUSY) || (state == WBUSY);
    assign drq    = (state == RDRQ)  || (state == WDRQ);
    assign status = {bsy, 1'b1, 2'b00, drq, 2'b00, err_flag};

    assign cmd_wr      = wr_act && sel && (ide.ide_da == 3'd7) && (state == IDLE);
    assign data_rd_evt = rd_act && sel && (ide.ide_da == 3'd0) && (state == RDRQ);
    assign data_wr_evt = wr_act && sel && (ide.ide_da == 3'd0) && (state == WDRQ);

    // State register of the command sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the one-cycle control pulses the datapath consumes.
    always_comb begin
        state_next  = state;
        load_cmd    = 1'b0;
        busy_load   = 1'b0;
        next_sector = 1'b0;
        set_err     = 1'b0;
        err_code    = 8'h00;
        case (state)
            IDLE: begin
                if (cmd_wr) begin
                    if ((ide.ide_data_in[7:0] == CMD_READ) || (ide.ide_data_in[7:0] == CMD_WRITE)) begin
                        if (lba_in_range) begin
                            load_cmd = 1'b1;
                            if (ide.ide_data_in[7:0] == CMD_READ) begin
                                state_next = RBUSY;
                                busy_load  = 1'b1;
                            end else begin
                                state_next = WDRQ;
                            end
                        end else begin
                            set_err  = 1'b1;
                            err_code = ERR_IDNF;
                        end
                    end else begin
                        set_err  = 1'b1;
                        err_code = ERR_ABRT;
                    end
                end
            end
            RBUSY: begin
                if (busy_cnt == 16'd0) begin
                    state_next = RDRQ;
                end
            end
            RDRQ: begin
                if (data_rd_evt && (ptr == 8'hFF)) begin
                    if (cnt > 9'd1) begin
                        next_sector = 1'b1;
                        if (next_in_range) begin
                            state_next = RBUSY;
                            busy_load  = 1'b1;
                        end else begin
                            state_next = IDLE;
                            set_err    = 1'b1;
                            err_code   = ERR_IDNF;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            WDRQ: begin
                if (data_wr_evt && (ptr == 8'hFF)) begin
                    state_next = WBUSY;
                    busy_load  = 1'b1;
                end
            end
            WBUSY: begin
                if (busy_cnt == 16'd0) begin
                    if (cnt > 9'd1) begin
                        next_sector = 1'b1;
                        if (next_in_range) begin
                            state_next = WDRQ;
                        end else begin
                            state_next = IDLE;
                            set_err    = 1'b1;
                            err_code   = ERR_IDNF;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Task file, error/status bits, transfer pointer and sector bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            dior_q    <= 1'b1;
            diow_q    <= 1'b1;
            error_reg <= 8'h00;
            features  <= 8'h00;
            seccnt    <= 8'h00;
            lba0      <= 8'h00;
            lba1      <= 8'h00;
            lba2      <= 8'h00;
            drive     <= 8'h00;
            err_flag  <= 1'b0;
            ptr       <= 8'h00;
            cnt       <= 9'd0;
            cur_lba   <= 24'd0;
            busy_cnt  <= 16'd0;
        end else begin
            dior_q <= ide.ide_dior;
            diow_q <= ide.ide_diow;

            if (wr_act && sel && !bsy) begin
                case (ide.ide_da)
                    3'd1:    features <= ide.ide_data_in[7:0];
                    3'd2:    seccnt   <= ide.ide_data_in[7:0];
                    3'd3:    lba0     <= ide.ide_data_in[7:0];
                    3'd4:    lba1     <= ide.ide_data_in[7:0];
                    3'd5:    lba2     <= ide.ide_data_in[7:0];
                    3'd6:    drive    <= ide.ide_data_in[7:0];
                    default: ;
                endcase
            end

            if (cmd_wr) begin
                err_flag  <= 1'b0;
                error_reg <= 8'h00;
            end
            if (set_err) begin
                err_flag  <= 1'b1;
                error_reg <= err_code;
            end

            if (load_cmd) begin
                cnt     <= (seccnt == 8'd0) ? 9'd256 : {1'b0, seccnt};
                cur_lba <= lba_full;
                ptr     <= 8'h00;
            end else if (data_rd_evt || data_wr_evt) begin
                ptr <= ptr + 8'd1;
            end

            if (next_sector) begin
                cnt     <= cnt - 9'd1;
                cur_lba <= cur_lba + 24'd1;
            end

            if (busy_load) begin
                busy_cnt <= 16'(BUSY_CYCLES - 1);
            end else if (bsy && (busy_cnt != 16'd0)) begin
                busy_cnt <= busy_cnt - 16'd1;
            end
        end
    end

    // Sector storage has no reset so its contents survive an aborted command.
    always_ff @(posedge clk) begin
        if (!reset && data_wr_evt) begin
            mem[{sect_idx, ptr}] <= ide.ide_data_in;
        end
    end

    // Register readback, driven only while the host holds a selected read strobe.
    always_comb begin
        ide.ide_data_out = 16'h0000;
        ide.ide_data_oe  = !reset && sel && !ide.ide_dior;
        if (ide.ide_data_oe) begin
            case (ide.ide_da)
                3'd0:    ide.ide_data_out = (state == RDRQ) ? mem[{sect_idx, ptr}] : 16'h0000;
                3'd1:    ide.ide_data_out = {8'h00, error_reg};
                3'd2:    ide.ide_data_out = {8'h00, seccnt};
                3'd3:    ide.ide_data_out = {8'h00, lba0};
                3'd4:    ide.ide_data_out = {8'h00, lba1};
                3'd5:    ide.ide_data_out = {8'h00, lba2};
                3'd6:    ide.ide_data_out = {8'h00, drive};
                default: ide.ide_data_out = {8'h00, status};
            endcase
        end
    end

`ifdef IDE_TARGET_IRQ_EN
    logic rdrq_entry;
    logic wr_done;
    logic status_rd;
    logic cmd_any;

    assign rdrq_entry = (state_next == RDRQ) && (state != RDRQ);
    assign wr_done    = (state == WBUSY) && (busy_cnt == 16'd0) && (cnt <= 9'd1);
    assign status_rd  = rd_act && sel && (ide.ide_da == 3'd7);
    assign cmd_any    = wr_act && sel && (ide.ide_da == 3'd7);

    // Interrupt: raising events win over a same-cycle status read or command write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ide_intrq <= 1'b0;
        end else if (rdrq_entry || wr_done || set_err) begin
            ide_intrq <= 1'b1;
        end else if (status_rd || cmd_any) begin
            ide_intrq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ide_target.sv
// Testbench for ide_target: drives PIO register cycles through ide_if and
// checks sector data and status against a behavioural model of the drive.
module tb_ide_target;

    localparam int NSECT       = 4;
    localparam int BUSY_CYCLES = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;
    logic rd_oe;

    logic [15:0] model_mem [0:NSECT*256-1];

    ide_if bus();

`ifdef IDE_TARGET_IRQ_EN
    logic intrq;
`endif

    ide_target #(
        .NSECT(NSECT),
        .BUSY_CYCLES(BUSY_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ide(bus)
`ifdef IDE_TARGET_IRQ_EN
        ,
        .ide_intrq(intrq)
`endif
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Compares the interrupt line when the design is built with it.
    task automatic checkIrq(input string tag, input logic expected);
`ifdef IDE_TARGET_IRQ_EN
        checkOutput(tag, {15'b0, intrq}, {15'b0, expected});
`endif
    endtask

    // One host register cycle: strobe low for a clock, released on a falling edge.
    task automatic applyStimulus(input bit is_read, input logic [2:0] addr,
                                 input logic [15:0] wdata, output logic [15:0] rdata);
        bus.ide_cs      = 2'b10;
        bus.ide_da      = addr;
        bus.ide_data_in = wdata;
        if (is_read) bus.ide_dior = 1'b0;
        else         bus.ide_diow = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rdata = bus.ide_data_out;
        rd_oe = bus.ide_data_oe;
        bus.ide_dior = 1'b1;
        bus.ide_diow = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [2:0] addr, input logic [15:0] data);
        logic [15:0] unused_rd;
        applyStimulus(1'b0, addr, data, unused_rd);
    endtask

    task automatic readReg(input logic [2:0] addr, output logic [15:0] data);
        applyStimulus(1'b1, addr, 16'h0000, data);
    endtask

    // Holds a status read open and counts clocks with BSY set until it clears.
    task automatic pollBusy(output int busy_n, output logic [15:0] last_status, output logic irq);
        busy_n      = 0;
        last_status = 16'h0000;
        irq         = 1'b0;
        bus.ide_cs  = 2'b10;
        bus.ide_da  = 3'd7;
        bus.ide_dior = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            last_status = bus.ide_data_out;
`ifdef IDE_TARGET_IRQ_EN
            irq = intrq;
`endif
            if (last_status[7]) busy_n++;
            else break;
        end
        bus.ide_dior = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.ide_cs   = 2'b10;
        bus.ide_da   = 3'd7;
        bus.ide_dior = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset oe", {15'b0, bus.ide_data_oe}, 16'h0000);
        checkOutput("reset data", bus.ide_data_out, 16'h0000);
        bus.ide_dior = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic setupTaskFile(input int lba, input int sc);
        writeReg(3'd2, 16'(sc & 255));
        writeReg(3'd3, 16'(lba & 255));
        writeReg(3'd4, 16'((lba >> 8) & 255));
        writeReg(3'd5, 16'((lba >> 16) & 255));
    endtask

    // Model: a command moves min(count, NSECT-lba) sectors and errors if it wanted more.
    function automatic int sectorsAvail(input int lba);
        return (lba < NSECT) ? (NSECT - lba) : 0;
    endfunction

    task automatic runWrite(input int lba, input int sc, input bit incr, input string tag);
        int n, avail, xfer, busy_n;
        bit err;
        logic [15:0] st, d, w;
        logic irq;
        n     = (sc == 0) ? 256 : sc;
        avail = sectorsAvail(lba);
        xfer  = (n < avail) ? n : avail;
        err   = (n > avail);
        setupTaskFile(lba, sc);
        writeReg(3'd7, 16'h0030);
        if (xfer == 0) begin
            checkIrq({tag, " irq on err"}, 1'b1);
        end else begin
            readReg(3'd7, st);
            checkOutput({tag, " drq status"}, st, 16'h0048);
        end
        for (int k = 0; k < xfer; k++) begin
            for (int i = 0; i < 256; i++) begin
                w = incr ? 16'(i) : 16'($urandom);
                model_mem[(lba + k) * 256 + i] = w;
                writeReg(3'd0, w);
            end
            pollBusy(busy_n, st, irq);
            checkOutput({tag, " busy clocks"}, 16'(busy_n), 16'(BUSY_CYCLES));
            if (k < xfer - 1) begin
                checkOutput({tag, " next drq"}, st, 16'h0048);
            end else begin
                checkOutput({tag, " end status"}, st, err ? 16'h0041 : 16'h0040);
`ifdef IDE_TARGET_IRQ_EN
                checkOutput({tag, " irq done"}, {15'b0, irq}, 16'h0001);
`endif
            end
        end
        if (xfer == 0) begin
            readReg(3'd7, st);
            checkOutput({tag, " err status"}, st, 16'h0041);
        end
        if (err) begin
            readReg(3'd1, d);
            checkOutput({tag, " error reg"}, d, 16'h0010);
        end
    endtask

    task automatic runRead(input int lba, input int sc, input string tag);
        int n, avail, xfer, busy_n;
        bit err;
        logic [15:0] st, d;
        logic irq;
        n     = (sc == 0) ? 256 : sc;
        avail = sectorsAvail(lba);
        xfer  = (n < avail) ? n : avail;
        err   = (n > avail);
        setupTaskFile(lba, sc);
        writeReg(3'd7, 16'h0020);
        for (int k = 0; k < xfer; k++) begin
            pollBusy(busy_n, st, irq);
            checkOutput({tag, " busy clocks"}, 16'(busy_n), 16'(BUSY_CYCLES));
            checkOutput({tag, " drq status"}, st, 16'h0048);
`ifdef IDE_TARGET_IRQ_EN
            checkOutput({tag, " irq at drq"}, {15'b0, irq}, 16'h0001);
            checkIrq({tag, " irq cleared"}, 1'b0);
`endif
            for (int i = 0; i < 256; i++) begin
                readReg(3'd0, d);
                checkOutput({tag, " word"}, d, model_mem[(lba + k) * 256 + i]);
            end
        end
        if (err) checkIrq({tag, " irq on err"}, 1'b1);
        readReg(3'd7, st);
        checkOutput({tag, " end status"}, st, err ? 16'h0041 : 16'h0040);
        if (err) begin
            readReg(3'd1, d);
            checkOutput({tag, " error reg"}, d, 16'h0010);
        end
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] st;
        logic irq;
        int busy_n;
        int s, c;

        bus.ide_dior    = 1'b1;
        bus.ide_diow    = 1'b1;
        bus.ide_cs      = 2'b11;
        bus.ide_da      = 3'd0;
        bus.ide_data_in = 16'h0000;
        for (int i = 0; i < NSECT * 256; i++) model_mem[i] = 16'h0000;

        doReset();
        checkOutput("oe idle", {15'b0, bus.ide_data_oe}, 16'h0000);
        readReg(3'd7, d);
        checkOutput("reset status", d, 16'h0040);
        checkOutput("oe during read", {15'b0, rd_oe}, 16'h0001);
        readReg(3'd1, d);
        checkOutput("reset error", d, 16'h0000);
        readReg(3'd2, d);
        checkOutput("reset seccnt", d, 16'h0000);
        checkIrq("irq after reset", 1'b0);

        runWrite(0, NSECT, 1'b0, "fill all");
        runRead(0, 0, "seccnt zero");

        runWrite(2, 1, 1'b1, "incr write");
        runRead(2, 1, "incr read");
        readReg(3'd2, d);
        checkOutput("seccnt kept", d, 16'h0001);

        readReg(3'd0, d);
        checkOutput("data idle read", d, 16'h0000);
        writeReg(3'd0, 16'hDEAD);

        writeReg(3'd7, 16'h00EC);
        checkIrq("irq bad cmd", 1'b1);
        readReg(3'd7, d);
        checkOutput("bad cmd status", d, 16'h0041);
        readReg(3'd1, d);
        checkOutput("bad cmd error", d, 16'h0004);
        checkIrq("irq status clr", 1'b0);
        runRead(2, 1, "after abort");
        readReg(3'd1, d);
        checkOutput("error cleared", d, 16'h0000);

        runRead(3, 2, "cross end");
        runRead(4, 1, "lba4 read");
        runWrite(5, 1, 1'b0, "lba5 write");
        runRead(32'h0001_0000, 1, "lba high");

        for (int r = 0; r < 4; r++) begin
            s = int'($urandom_range(0, NSECT - 1));
            c = int'($urandom_range(1, NSECT - s));
            runWrite(s, c, 1'b0, "rand write");
            runRead(s, c, "rand read");
        end

        setupTaskFile(1, 1);
        writeReg(3'd7, 16'h0020);
        writeReg(3'd2, 16'h0055);
        pollBusy(busy_n, st, irq);
        checkOutput("abort drq", st, 16'h0048);
        writeReg(3'd7, 16'h00EC);
        readReg(3'd7, d);
        checkOutput("cmd ignored", d, 16'h0048);
        readReg(3'd2, d);
        checkOutput("busy write ignored", d, 16'h0001);
        for (int i = 0; i < 100; i++) begin
            readReg(3'd0, d);
            checkOutput("partial word", d, model_mem[256 + i]);
        end
        doReset();
        readReg(3'd7, d);
        checkOutput("abort status", d, 16'h0040);
        readReg(3'd2, d);
        checkOutput("abort seccnt", d, 16'h0000);
        checkIrq("abort irq", 1'b0);
        runRead(1, 1, "reread");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
